saw_ctrl: RTL and testbench
===========================

// Module: saw_ctrl
// PURPOSE
//  Sequencer for the LED bar decoder. Generates the 8-bit sawtooth count and
//  holds the active window bounds N1/N2. New bounds enter through a
//  valid/ready handshake and take effect only at a sawtooth wrap, so the
//  decoder never sees a mid-sweep bound change. Sits between the
//  front-panel/config logic and led_dec (drives its N1/N2/sawtooth inputs).
// PARAMETERS
//  CNT_MAX   255  sawtooth top value; count runs 0..CNT_MAX then wraps (<=255)
//  PRESC     4    clocks per sawtooth step (>=1; 1 = step every clock)
//  N1_RST    0    active N1 after reset
//  N2_RST    255  active N2 after reset
// PORTS
//  clc_i            in   1  clock, all logic on rising edge
//  rst_i            in   1  async reset, active low
//  en_i             in   1  1 = run sweep, 0 = stop and clear count
//  cfg_valid_i      in   1  new bounds offered
//  cfg_ready_o      out  1  shadow slot free; transfer when valid&ready
//  cfg_n1_i         in   8  requested lower bound
//  cfg_n2_i         in   8  requested upper bound
//  N1_data_o        out  8  active lower bound
//  N2_data_o        out  8  active upper bound
//  sawtooth_cntr_o  out  8  current sawtooth value
//  wrap_o           out  1  1-clk strobe, count CNT_MAX->0 this edge
//  in_window_o      out  1  N1_data_o <= sawtooth_cntr_o <= N2_data_o
//  cfg_err_o        out  1  1-clk strobe, offered cfg rejected (n1 > n2)
// BEHAVIOUR
//  Reset: state IDLE, presc cnt 0, sawtooth 0, N1/N2 = N1_RST/N2_RST,
//   shadow empty, cfg_ready_o 1, wrap_o 0, cfg_err_o 0.
//  FSM: IDLE --en_i=1--> RUN; RUN --en_i=0--> IDLE. Any state: rst_i low -> reset.
//  IDLE: presc and sawtooth held 0; a pending shadow is applied at once.
//  RUN: presc counts 0..PRESC-1; at PRESC-1 it returns to 0 and the sawtooth
//   steps +1. At CNT_MAX, the step goes to 0 and asserts wrap_o on that edge.
//  en_i fall: sawtooth and presc are 0 on the next edge. No wrap_o. The
//   shadow is applied on the following IDLE cycle.
//  Handshake: cfg_ready_o = shadow empty. A transfer (valid & ready) with
//   n1 <= n2 loads the shadow (full, ready 0 next cycle).
//  Transfer with n1 > n2: shadow stays empty, cfg_err_o = 1 next cycle,
//   active bounds unchanged. cfg_valid_i while ready=0: ignored, no error.
//  Apply: on the wrap edge (or IDLE cycle), N1/N2 <= shadow, shadow empties,
//   ready 1 next cycle.
//  Transfer and wrap on the same edge: the new cfg fills the shadow and is
//   applied at the NEXT wrap, not this one.
//  in_window_o: combinational from registered count/bounds, 0-cycle latency.
//   n1 == n2 gives a window one count wide.
//  Widths: counters unsigned, no overflow beyond CNT_MAX; cfg compare is
//   unsigned 8-bit.
//  Reset mid-sweep or mid-handshake: the pending shadow is discarded and the
//   bounds revert to N1_RST/N2_RST.
// TESTING
//  1 PRESC=1, CNT_MAX=255, en_i=1 from reset -> count 0,1..255,0; wrap_o
//    high exactly one clk per 256 clks, on the 255->0 edge.
//  2 RUN, count=10, offer n1=20 n2=40 -> accepted, ready 0. N1/N2 stay
//    0/255 until wrap, then 20/40, ready 1. in_window_o is 1 only for 20..40.
//  3 Offer n1=50 n2=30 -> cfg_err_o one pulse next clk; bounds unchanged;
//    ready stays 1.
//  4 Offer transfer on the same edge as the wrap -> applied at the next wrap
//    (256*PRESC clks later), not the current one.
//  5 en_i=0 with shadow full (n1=5 n2=6) -> count 0, no wrap_o; bounds 5/6
//    one clk later. en_i=1 resumes from 0.
//  6 rst_i low mid-sweep with shadow full -> all outputs at reset values
//    immediately (async); shadow lost, ready 1.

Source files
------------

// File: rtl/saw_ctrl.sv
// Sawtooth sequencer for the LED bar decoder: prescaled 8-bit sweep plus
// N1/N2 window bounds that are updated through a shadow slot at sweep wrap.
module saw_ctrl #(
  parameter int unsigned CNT_MAX = 255,
  parameter int unsigned PRESC   = 4,
  parameter logic [7:0]  N1_RST  = 8'd0,
  parameter logic [7:0]  N2_RST  = 8'd255
) (
  input  logic       clc_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [7:0] cfg_n1_i,
  input  logic [7:0] cfg_n2_i,
  output logic [7:0] N1_data_o,
  output logic [7:0] N2_data_o,
  output logic [7:0] sawtooth_cntr_o,
  output logic       wrap_o,
  output logic       in_window_o,
  output logic       cfg_err_o
);

  localparam int unsigned   PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [7:0]    CNT_TOP    = 8'(CNT_MAX);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    saw_q, saw_d;
  logic [7:0]    n1_q, n1_d, n2_q, n2_d;
  logic [7:0]    sh_n1_q, sh_n1_d, sh_n2_q, sh_n2_d;
  logic          sh_full_q, sh_full_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic running, step_tick, wrap_hit, xfer, cfg_ok, apply;

  // Inclusive unsigned range test shared by window output and cfg check.
  function automatic logic in_range(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = RUN;
      RUN:     if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running   = (state_q == RUN) && en_i;
    step_tick = running && (presc_q == PRESC_LAST);
    wrap_hit  = step_tick && (saw_q == CNT_TOP);

    presc_d = '0;
    saw_d   = 8'd0;
    if (running) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      saw_d   = saw_q;
      if (step_tick) saw_d = wrap_hit ? 8'd0 : saw_q + 8'd1;
    end
    wrap_d = wrap_hit;
  end

  // Shadow slot: filled by an accepted offer, drained at wrap or while idle.
  // Apply and fill are exclusive since a fill requires an empty slot.
  always_comb begin
    cfg_ok = in_range(cfg_n1_i, 8'd0, cfg_n2_i);
    xfer   = cfg_valid_i && !sh_full_q;
    apply  = sh_full_q && (wrap_hit || (state_q == IDLE));

    n1_d      = n1_q;
    n2_d      = n2_q;
    sh_n1_d   = sh_n1_q;
    sh_n2_d   = sh_n2_q;
    sh_full_d = sh_full_q;
    err_d     = 1'b0;

    if (apply) begin
      n1_d      = sh_n1_q;
      n2_d      = sh_n2_q;
      sh_full_d = 1'b0;
    end else if (xfer) begin
      if (cfg_ok) begin
        sh_n1_d   = cfg_n1_i;
        sh_n2_d   = cfg_n2_i;
        sh_full_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Register stage: all sequencer state.
  always_ff @(posedge clc_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      saw_q     <= 8'd0;
      n1_q      <= N1_RST;
      n2_q      <= N2_RST;
      sh_n1_q   <= 8'd0;
      sh_n2_q   <= 8'd0;
      sh_full_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      saw_q     <= saw_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      sh_n1_q   <= sh_n1_d;
      sh_n2_q   <= sh_n2_d;
      sh_full_q <= sh_full_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready_o     = !sh_full_q;
  assign N1_data_o       = n1_q;
  assign N2_data_o       = n2_q;
  assign sawtooth_cntr_o = saw_q;
  assign wrap_o          = wrap_q;
  assign cfg_err_o       = err_q;
  assign in_window_o     = in_range(saw_q, n1_q, n2_q);

endmodule

// File: tb/tb_saw_ctrl.sv
// Directed bench for saw_ctrl: a PRESC=1 instance carries the scenarios,
// a PRESC=4 instance on the same inputs checks the prescaled step rate.
module tb_saw_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, cfg_valid;
  logic [7:0] cfg_n1, cfg_n2;

  logic       ready, wrap, in_win, err;
  logic [7:0] n1, n2, cnt;
  logic       ready4, wrap4, in_win4, err4;
  logic [7:0] n1_4, n2_4, cnt4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  saw_ctrl #(.CNT_MAX(255), .PRESC(1), .N1_RST(8'd0), .N2_RST(8'd255)) u_dut (
    .clc_i(clk), .rst_i(rst_n), .en_i(en), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(ready), .cfg_n1_i(cfg_n1), .cfg_n2_i(cfg_n2),
    .N1_data_o(n1), .N2_data_o(n2), .sawtooth_cntr_o(cnt),
    .wrap_o(wrap), .in_window_o(in_win), .cfg_err_o(err)
  );

  saw_ctrl #(.CNT_MAX(255), .PRESC(4), .N1_RST(8'd0), .N2_RST(8'd255)) u_dut4 (
    .clc_i(clk), .rst_i(rst_n), .en_i(en), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(ready4), .cfg_n1_i(cfg_n1), .cfg_n2_i(cfg_n2),
    .N1_data_o(n1_4), .N2_data_o(n2_4), .sawtooth_cntr_o(cnt4),
    .wrap_o(wrap4), .in_window_o(in_win4), .cfg_err_o(err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_n1 = 8'd0; cfg_n2 = 8'd0;
    repeat (3) step();
    vectors++;
    if ({cnt, n1, n2, ready, wrap, err, in_win} !== {8'd0, 8'd0, 8'd255, 4'b1001}) begin
      miscompares++;
      $display("FAIL reset_state got cnt=%0d n1=%0d n2=%0d rdy=%b wrap=%b err=%b win=%b want 0 0 255 1 0 0 1",
               cnt, n1, n2, ready, wrap, err, in_win);
    end
    vectors++;
    if (cnt4 !== 8'd0) begin
      miscompares++; $display("FAIL reset_cnt4 got %0d want 0", cnt4);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (cnt !== 8'd0 || wrap !== 1'b0) begin
      miscompares++; $display("FAIL idle_hold got cnt=%0d wrap=%b want 0 0", cnt, wrap);
    end
  endtask

  task automatic test_sweep();
    int exp_c;
    en = 1'b1;
    step();
    vectors++;
    if (cnt !== 8'd0) begin
      miscompares++; $display("FAIL sweep_start got %0d want 0", cnt);
    end
    for (int k = 2; k <= 513; k++) begin
      step();
      exp_c = (k - 1) % 256;
      vectors++;
      if (cnt !== 8'(exp_c) || wrap !== (exp_c == 0)) begin
        miscompares++;
        $display("FAIL sweep k=%0d got cnt=%0d wrap=%b want %0d %b", k, cnt, wrap, exp_c, exp_c == 0);
      end
      vectors++;
      if (cnt4 !== 8'((k - 1) / 4) || wrap4 !== 1'b0) begin
        miscompares++;
        $display("FAIL presc4 k=%0d got cnt=%0d wrap=%b want %0d 0", k, cnt4, wrap4, (k - 1) / 4);
      end
    end
    en = 1'b0;
    step();
    vectors++;
    if (cnt !== 8'd0 || wrap !== 1'b0 || cnt4 !== 8'd0) begin
      miscompares++; $display("FAIL sweep_stop got cnt=%0d wrap=%b cnt4=%0d want 0 0 0", cnt, wrap, cnt4);
    end
  endtask

  task automatic test_cfg_accept();
    en = 1'b1;
    step();
    repeat (10) step();
    vectors++;
    if (cnt !== 8'd10 || ready !== 1'b1) begin
      miscompares++; $display("FAIL acc_pre got cnt=%0d rdy=%b want 10 1", cnt, ready);
    end
    cfg_valid = 1'b1; cfg_n1 = 8'd20; cfg_n2 = 8'd40;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if ({cnt, n1, n2, ready} !== {8'd11, 8'd0, 8'd255, 1'b0}) begin
      miscompares++;
      $display("FAIL acc_load got cnt=%0d n1=%0d n2=%0d rdy=%b want 11 0 255 0", cnt, n1, n2, ready);
    end
    for (int i = 12; i <= 256; i++) begin
      step();
      vectors++;
      if (i < 256) begin
        if ({n1, n2, ready, wrap} !== {8'd0, 8'd255, 2'b00}) begin
          miscompares++;
          $display("FAIL acc_hold cnt=%0d got n1=%0d n2=%0d rdy=%b wrap=%b want 0 255 0 0", cnt, n1, n2, ready, wrap);
        end
      end else begin
        if ({cnt, n1, n2, ready, wrap} !== {8'd0, 8'd20, 8'd40, 2'b11}) begin
          miscompares++;
          $display("FAIL acc_apply got cnt=%0d n1=%0d n2=%0d rdy=%b wrap=%b want 0 20 40 1 1", cnt, n1, n2, ready, wrap);
        end
      end
    end
    for (int j = 1; j <= 255; j++) begin
      step();
      vectors++;
      if (cnt !== 8'(j) || in_win !== (j >= 20 && j <= 40)) begin
        miscompares++;
        $display("FAIL window_20_40 got cnt=%0d win=%b want %0d %b", cnt, in_win, j, (j >= 20 && j <= 40));
      end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_cfg_err();
    en = 1'b1;
    step();
    repeat (3) step();
    cfg_valid = 1'b1; cfg_n1 = 8'd50; cfg_n2 = 8'd30;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if ({err, ready, n1, n2} !== {2'b11, 8'd20, 8'd40}) begin
      miscompares++;
      $display("FAIL err_pulse got err=%0b rdy=%b n1=%0d n2=%0d want 1 1 20 40", err, ready, n1, n2);
    end
    step();
    vectors++;
    if (err !== 1'b0 || cnt !== 8'd5) begin
      miscompares++; $display("FAIL err_clear got err=%b cnt=%0d want 0 5", err, cnt);
    end
    cfg_valid = 1'b1; cfg_n1 = 8'd30; cfg_n2 = 8'd60;
    step();
    vectors++;
    if (ready !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL err_goodload got rdy=%b err=%b want 0 0", ready, err);
    end
    cfg_n1 = 8'd50; cfg_n2 = 8'd30;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if ({err, ready, n1, n2} !== {2'b00, 8'd20, 8'd40}) begin
      miscompares++;
      $display("FAIL err_ignored got err=%b rdy=%b n1=%0d n2=%0d want 0 0 20 40", err, ready, n1, n2);
    end
    en = 1'b0;
    step();
    step();
    vectors++;
    if ({n1, n2, ready} !== {8'd30, 8'd60, 1'b1}) begin
      miscompares++; $display("FAIL err_idle_apply got n1=%0d n2=%0d rdy=%b want 30 60 1", n1, n2, ready);
    end
  endtask

  task automatic test_stop_apply();
    en = 1'b1;
    step();
    repeat (254) step();
    cfg_valid = 1'b1; cfg_n1 = 8'd5; cfg_n2 = 8'd6;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if (cnt !== 8'd255 || ready !== 1'b0) begin
      miscompares++; $display("FAIL stop_pre got cnt=%0d rdy=%b want 255 0", cnt, ready);
    end
    en = 1'b0;
    step();
    vectors++;
    if ({cnt, wrap, n1, n2} !== {8'd0, 1'b0, 8'd30, 8'd60}) begin
      miscompares++;
      $display("FAIL stop_edge got cnt=%0d wrap=%b n1=%0d n2=%0d want 0 0 30 60", cnt, wrap, n1, n2);
    end
    step();
    vectors++;
    if ({cnt, n1, n2, ready} !== {8'd0, 8'd5, 8'd6, 1'b1}) begin
      miscompares++;
      $display("FAIL stop_apply got cnt=%0d n1=%0d n2=%0d rdy=%b want 0 5 6 1", cnt, n1, n2, ready);
    end
    en = 1'b1;
    step();
    step();
    vectors++;
    if (cnt !== 8'd1) begin
      miscompares++; $display("FAIL resume got cnt=%0d want 1", cnt);
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_wrap_xfer();
    en = 1'b1;
    step();
    repeat (255) step();
    vectors++;
    if (cnt !== 8'd255) begin
      miscompares++; $display("FAIL wx_pre got cnt=%0d want 255", cnt);
    end
    cfg_valid = 1'b1; cfg_n1 = 8'd100; cfg_n2 = 8'd100;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if ({cnt, wrap, n1, n2, ready} !== {8'd0, 1'b1, 8'd5, 8'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL wx_same_edge got cnt=%0d wrap=%b n1=%0d n2=%0d rdy=%b want 0 1 5 6 0", cnt, wrap, n1, n2, ready);
    end
    for (int j = 1; j <= 255; j++) begin
      step();
      vectors++;
      if ({n1, n2, ready} !== {8'd5, 8'd6, 1'b0} || in_win !== (j == 5 || j == 6)) begin
        miscompares++;
        $display("FAIL wx_lap cnt=%0d got n1=%0d n2=%0d rdy=%b win=%b want 5 6 0 %b", cnt, n1, n2, ready, in_win, (j == 5 || j == 6));
      end
    end
    step();
    vectors++;
    if ({cnt, wrap, n1, n2, ready} !== {8'd0, 1'b1, 8'd100, 8'd100, 1'b1}) begin
      miscompares++;
      $display("FAIL wx_next_wrap got cnt=%0d wrap=%b n1=%0d n2=%0d rdy=%b want 0 1 100 100 1", cnt, wrap, n1, n2, ready);
    end
    for (int j = 1; j <= 101; j++) begin
      step();
      if (j >= 99) begin
        vectors++;
        if (in_win !== (j == 100)) begin
          miscompares++; $display("FAIL window_one cnt=%0d got win=%b want %b", cnt, in_win, (j == 100));
        end
      end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    step();
    repeat (50) step();
    cfg_valid = 1'b1; cfg_n1 = 8'd10; cfg_n2 = 8'd20;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if (ready !== 1'b0 || cnt !== 8'd51) begin
      miscompares++; $display("FAIL ar_pre got rdy=%b cnt=%0d want 0 51", ready, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({cnt, n1, n2, ready, wrap, err, in_win} !== {8'd0, 8'd0, 8'd255, 4'b1001}) begin
      miscompares++;
      $display("FAIL ar_immediate got cnt=%0d n1=%0d n2=%0d rdy=%b wrap=%b err=%b win=%b want 0 0 255 1 0 0 1",
               cnt, n1, n2, ready, wrap, err, in_win);
    end
    en = 1'b0;
    #1 rst_n = 1'b1;
    step();
    step();
    vectors++;
    if ({cnt, n1, n2, ready} !== {8'd0, 8'd0, 8'd255, 1'b1}) begin
      miscompares++;
      $display("FAIL ar_shadow_lost got cnt=%0d n1=%0d n2=%0d rdy=%b want 0 0 255 1", cnt, n1, n2, ready);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_cfg_accept();
    test_cfg_err();
    test_stop_apply();
    test_wrap_xfer();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
